// File: rtl/win_scan_pkg.sv
// Shared types and defaults for the sliding-window scan controller.
package win_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDone
    } scan_state_e;

    localparam int unsigned WinDefault = 7;

endpackage

// File: rtl/scan_counter.sv
// Raster-order column/row counter; clr has priority over inc.
module scan_counter #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    input  logic                       clr,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic                       last
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_max, row_max;

    assign col_max = (col_q == CW'(IMG_W - 1));
    assign row_max = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (col_max) begin
                col_d = '0;
                row_d = row_max ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = col_max && row_max;

endmodule

// File: rtl/window_scan_ctrl.sv
// Sliding WIN x WIN window scan controller for a raster pixel stream.
// Define WIN_SCAN_FRAME_CNT_EN to add a 16-bit completed-frame counter output.
module window_scan_ctrl
    import win_scan_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned WIN   = WinDefault
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic                       out_ready,
    output logic                       shift_en,
    output logic [$clog2(IMG_W)-1:0]   col,
    output logic [$clog2(IMG_H)-1:0]   row,
    output logic                       win_valid,
    output logic                       frame_done,
`ifdef WIN_SCAN_FRAME_CNT_EN
    output logic [15:0]                frame_cnt,
`endif
    output logic                       busy
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    scan_state_e state_q;
    logic        win_valid_q;
    logic        frame_done_q;
    logic        active;
    logic        transfer;
    logic        last;
    logic        win_hit;
    logic        fill_end;
    logic        cnt_clr;

    assign active    = (state_q == StFill) || (state_q == StRun);
    // frame_start blocks the transfer so an abort never consumes a pixel.
    assign pix_ready = active && out_ready && !frame_start;
    assign transfer  = pix_valid && pix_ready;
    assign shift_en  = transfer;

    assign win_hit  = (col >= CW'(WIN - 1)) && (row >= RW'(WIN - 1));
    assign fill_end = (col == CW'(WIN - 1)) && (row == RW'(WIN - 1));
    assign cnt_clr  = frame_start || (transfer && last);

    scan_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_scan_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (transfer),
        .clr  (cnt_clr),
        .col  (col),
        .row  (row),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= transfer && win_hit;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_start) state_q <= StFill;
                end
                StFill, StRun: begin
                    if (frame_start) begin
                        state_q <= StFill;
                    end else if (transfer && last) begin
                        state_q      <= StDone;
                        frame_done_q <= 1'b1;
                    end else if (state_q == StFill && transfer && fill_end) begin
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    state_q <= frame_start ? StFill : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WIN_SCAN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 16'd0;
        end else if (transfer && last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Scoreboard bench for window_scan_ctrl at 8x8 image, 7x7 window.
module tb_window_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       pix_valid;
    logic       pix_ready;
    logic       out_ready;
    logic       shift_en;
    logic [2:0] col;
    logic [2:0] row;
    logic       win_valid;
    logic       frame_done;
    logic       busy;
`ifdef WIN_SCAN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    window_scan_ctrl #(
        .IMG_W (8),
        .IMG_H (8),
        .WIN   (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .out_ready   (out_ready),
        .shift_en    (shift_en),
        .col         (col),
        .row         (row),
        .win_valid   (win_valid),
        .frame_done  (frame_done),
`ifdef WIN_SCAN_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {row, col} of each transfer, of the transfer behind each win_valid
    // pulse, and of the last transfer behind each frame_done pulse.
    logic [5:0] exp_xfer[$];
    logic [5:0] exp_win[$];
    logic [5:0] exp_done[$];

    logic [5:0] prev_xfer = 6'd0;
    int         xfer_seen = 0;
    int         win_seen  = 0;
    int         done_seen = 0;

    logic [2:0] er;
    logic [2:0] ec;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst) begin
            if (win_valid) begin
                win_seen++;
                checks++;
                if (exp_win.size() == 0) begin
                    errors++;
                    $display("FAIL win_unexpected: got pulse after %0h expected none", prev_xfer);
                end else begin
                    logic [5:0] e;
                    e = exp_win.pop_front();
                    if (e != prev_xfer) begin
                        errors++;
                        $display("FAIL win_pos: got %0h expected %0h", prev_xfer, e);
                    end
                end
            end
            if (frame_done) begin
                done_seen++;
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got pulse after %0h expected none", prev_xfer);
                end else begin
                    logic [5:0] e;
                    e = exp_done.pop_front();
                    if (e != prev_xfer) begin
                        errors++;
                        $display("FAIL done_pos: got %0h expected %0h", prev_xfer, e);
                    end
                end
            end
            if (shift_en) begin
                xfer_seen++;
                checks++;
                if (exp_xfer.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got %0h expected none", {row, col});
                end else begin
                    logic [5:0] e;
                    e = exp_xfer.pop_front();
                    if (e != {row, col}) begin
                        errors++;
                        $display("FAIL xfer_pos: got %0h expected %0h", {row, col}, e);
                    end
                end
                prev_xfer = {row, col};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        er = 3'd0;
        ec = 3'd0;
    endtask

    // n cycles with pix_valid and out_ready high; each one is a transfer.
    task automatic xfer_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_xfer.push_back({er, ec});
            if (er >= 3'd6 && ec >= 3'd6) exp_win.push_back({er, ec});
            if (er == 3'd7 && ec == 3'd7) exp_done.push_back({er, ec});
            if (ec == 3'd7) begin
                ec = 3'd0;
                er = er + 3'd1;
            end else begin
                ec = ec + 3'd1;
            end
            step();
        end
    endtask

    initial begin
        int xb, wb, db;
        rst         = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        out_ready   = 1'b0;
        er          = 3'd0;
        ec          = 3'd0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        #10 rst = 1'b1;
        step();

        // Idle: pix_valid ignored.
        pix_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk("idle_pix_ready", int'(pix_ready), 0);
            chk("idle_col", int'(col), 0);
            chk("idle_row", int'(row), 0);
            step();
        end

        // Full frame.
        xb = xfer_seen; wb = win_seen; db = done_seen;
        start_frame();
        chk("fill_busy", int'(busy), 1);
        xfer_cycles(64);
        chk("done_busy", int'(busy), 1);
        step();
        chk("frame_xfers", xfer_seen - xb, 64);
        chk("frame_wins", win_seen - wb, 4);
        chk("frame_dones", done_seen - db, 1);
        chk("after_done_busy", int'(busy), 0);

        // Backpressure at row 2, col 4.
        xb = xfer_seen;
        start_frame();
        xfer_cycles(20);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("bp_pix_ready", int'(pix_ready), 0);
            chk("bp_shift_en", int'(shift_en), 0);
            chk("bp_col", int'(col), 4);
            chk("bp_row", int'(row), 2);
            step();
        end
        out_ready = 1'b1;
        xfer_cycles(44);
        step();
        chk("bp_frame_xfers", xfer_seen - xb, 64);

        // Abort at row 3, then a clean frame.
        start_frame();
        xfer_cycles(24);
        db = done_seen;
        frame_start = 1'b1;
        #3;
        chk("abort_pix_ready", int'(pix_ready), 0);
        chk("abort_shift_en", int'(shift_en), 0);
        step();
        frame_start = 1'b0;
        er = 3'd0;
        ec = 3'd0;
        chk("abort_col", int'(col), 0);
        chk("abort_row", int'(row), 0);
        chk("abort_busy", int'(busy), 1);
        xb = xfer_seen;
        xfer_cycles(64);
        step();
        chk("abort_next_xfers", xfer_seen - xb, 64);
        chk("abort_dones", done_seen - db, 1);
`ifdef WIN_SCAN_FRAME_CNT_EN
        chk("frame_cnt_3", int'(frame_cnt), 3);
`endif

        // Reset right after the (6,6) transfer: win_valid must drop at once.
        start_frame();
        xfer_cycles(55);
        exp_win.delete();
        db = done_seen;
        rst = 1'b0;
        #1;
        chk("mrst_win_valid", int'(win_valid), 0);
        chk("mrst_frame_done", int'(frame_done), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_col", int'(col), 0);
        chk("mrst_row", int'(row), 0);
        chk("mrst_pix_ready", int'(pix_ready), 0);
        chk("mrst_shift_en", int'(shift_en), 0);
`ifdef WIN_SCAN_FRAME_CNT_EN
        chk("mrst_frame_cnt", int'(frame_cnt), 0);
`endif
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_busy", int'(busy), 0);
        end
        chk("mrst_no_done", done_seen - db, 0);

        chk("xfer_q_empty", exp_xfer.size(), 0);
        chk("win_q_empty", exp_win.size(), 0);
        chk("done_q_empty", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per image row.
REQ-002 SHALL have parameter IMG_H, default 480, rows per image.
REQ-003 SHALL have parameter WIN, default 7, window edge in pixels; odd, 3 <= WIN <= min(IMG_W, IMG_H).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse that starts or restarts a frame scan.
REQ-007 SHALL have port pix_valid  input  1  upstream pixel column available.
REQ-008 SHALL have port pix_ready  output  1  block accepts the pixel column this cycle.
REQ-009 SHALL have port out_ready  input  1  downstream able to take a window this cycle.
REQ-010 SHALL have port shift_en  output  1  advance window shift registers and line buffers.
REQ-011 SHALL have port col  output  $clog2(IMG_W)  column index of the next pixel to accept.
REQ-012 SHALL have port row  output  $clog2(IMG_H)  row index of the next pixel to accept.
REQ-013 SHALL have port win_valid  output  1  window contents are a complete WIN x WIN neighbourhood.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, FILL, RUN, DONE.
REQ-017 Transfer SHALL occur when pix_valid && pix_ready.
REQ-018 pix_ready SHALL equal (state is FILL or RUN) && out_ready && !frame_start, combinationally.
REQ-019 shift_en SHALL equal transfer, combinationally (0-cycle latency).
REQ-020 On each transfer, col SHALL increment; at IMG_W-1 it SHALL wrap to 0 and row SHALL increment.
REQ-021 With no transfer, col and row SHALL hold.
REQ-022 win_valid SHALL be registered and go high for exactly one cycle after a transfer with col >= WIN-1 and row >= WIN-1 (1-cycle latency); otherwise 0.
REQ-023 IDLE -> FILL on frame_start; col and row cleared to 0.
REQ-024 FILL -> RUN on the transfer at col == WIN-1, row == WIN-1.
REQ-025 FILL or RUN -> DONE on the transfer at col == IMG_W-1, row == IMG_H-1; col and row cleared to 0.
REQ-026 DONE SHALL last one cycle with frame_done = 1, then go to IDLE.
REQ-027 frame_start in FILL, RUN or DONE SHALL abort: col and row cleared to 0, next state FILL, no frame_done, no transfer that cycle.
REQ-028 frame_start and the last-pixel transfer cannot coincide (REQ-018); frame_start SHALL win.
REQ-029 In IDLE, pix_valid SHALL be ignored, pix_ready = 0 and shift_en = 0.

Reset
REQ-030 rst low SHALL immediately force state IDLE, col = 0, row = 0, win_valid = 0, frame_done = 0 and busy = 0.
REQ-031 Reset mid-frame SHALL discard the frame with no frame_done pulse.
REQ-032 Combinational outputs pix_ready and shift_en SHALL read 0 while in reset.

Configuration
REQ-033 With macro WIN_SCAN_FRAME_CNT_EN defined, the block SHALL add output frame_cnt (16 bits).
REQ-034 frame_cnt SHALL reset to 0 and increment on each frame_done, wrapping 65535 -> 0.
REQ-035 Without WIN_SCAN_FRAME_CNT_EN, port frame_cnt and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-036 Package win_scan_pkg SHALL hold the state enumeration and the WIN default constant.
REQ-037 The col/row counter pair SHALL be one sub-module, scan_counter, with inputs inc and clr and outputs col, row and last.

Verification (IMG_W = 8, IMG_H = 8, WIN = 7)
REQ-038 Reset: assert rst low mid-simulation -> all registered outputs 0 and busy 0 in the same cycle.
REQ-039 Full frame: frame_start, then pix_valid and out_ready held at 1 -> exactly 64 transfers; win_valid high for 4 cycles (row/col 6-7); frame_done once, 1 cycle after transfer 64.
REQ-040 Backpressure: out_ready = 0 for 3 cycles at row 2, col 4 -> pix_ready = 0 and shift_en = 0 for those 3 cycles; col and row stay at 4 and 2.
REQ-041 Abort: frame_start at row 3 -> col = 0, row = 0, no frame_done; the next frame completes with 64 transfers.
REQ-042 Idle: pix_valid = 1 in IDLE for 10 cycles -> no shift_en, col and row stay at 0.
REQ-043 With WIN_SCAN_FRAME_CNT_EN: three complete frames -> frame_cnt = 3.
